pts_tx_controller: RTL and testbench

Transmit sequencer for the flexible parallel-to-serial shift register. It accepts one NUM_BITS-wide word per valid/ready handshake and presents it on the register's parallel input. It pulses the register's load enable, then issues one shift-enable pulse every CLKS_PER_BIT cycles until all NUM_BITS bits have been held on the serial line for a full bit period. It sits between the packet/byte source and the shift register, and owns all load/shift timing for the serial transmitter.

---
 rtl/pts_tx_controller.sv | 162 ++++++++++++++++
 tb/tb_pts_tx_controller.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pts_tx_controller.sv
// pts_tx_controller
//
// Transmit sequencer for a flexible parallel-to-serial shift register.
// It accepts one word per valid/ready handshake and presents it on the
// register's parallel input. It then issues a one-cycle load pulse,
// followed by one shift pulse per bit period until every bit has been held
// on the serial line for CLKS_PER_BIT cycles.
//
// Parameters:
//   NUM_BITS      word width; must match the shift register (>= 2)
//   CLKS_PER_BIT  clock cycles each bit is held on the line (>= 1)
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous, active-high reset
//   tx_valid      source has a word on tx_data
//   tx_data       word to transmit; sampled only on the accept edge
//   tx_ready      controller can accept a word (IDLE only)
//   pts_data      captured word, drives the shift register parallel_in
//   load_enable   one-cycle load pulse to the shift register
//   shift_enable  one-cycle shift pulse to the shift register
//   busy          high in every state except IDLE
//   tx_done       one-cycle pulse coinciding with the final shift pulse
//
// Build option:
//   PTS_TX_CONTROLLER_GAP_EN  when defined, an idle-high GAP of
//   CLKS_PER_BIT cycles follows every frame before returning to IDLE.

module pts_tx_controller #(
  parameter int NUM_BITS     = 8,
  parameter int CLKS_PER_BIT = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_valid,
  input  logic [NUM_BITS-1:0] tx_data,
  output logic                tx_ready,
  output logic [NUM_BITS-1:0] pts_data,
  output logic                load_enable,
  output logic                shift_enable,
  output logic                busy,
  output logic                tx_done
);

  localparam int CLK_W = $clog2(CLKS_PER_BIT + 1);
  localparam int BIT_W = $clog2(NUM_BITS + 1);

  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);
  localparam logic [CLK_W-1:0] CLK_ONE  = CLK_W'(1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

`ifdef PTS_TX_CONTROLLER_GAP_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_GAP   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [CLK_W-1:0]    clk_cnt_q, clk_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [NUM_BITS-1:0] pts_data_q, pts_data_d;

  logic clk_last;
  logic bit_last;

  assign clk_last = (clk_cnt_q == CLK_LAST);
  assign bit_last = (bit_cnt_q == BIT_LAST);

  // Outputs decode only registered state, so no input reaches an output
  // combinationally. LOAD and SHIFT are distinct states, which keeps the
  // load and shift pulses mutually exclusive.
  always_comb begin
    tx_ready     = (state_q == S_IDLE);
    busy         = (state_q != S_IDLE);
    load_enable  = (state_q == S_LOAD);
    shift_enable = (state_q == S_SHIFT) && clk_last;
    tx_done      = (state_q == S_SHIFT) && clk_last && bit_last;
    pts_data     = pts_data_q;
  end

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    pts_data_d = pts_data_q;

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d    = S_LOAD;
          clk_cnt_d  = '0;
          bit_cnt_d  = '0;
          pts_data_d = tx_data;
        end
      end

      S_LOAD: begin
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        if (clk_last) begin
          clk_cnt_d = '0;
          // bit_cnt reaches NUM_BITS on the final pulse; its width holds
          // that value, and it is cleared again on the next accept.
          bit_cnt_d = bit_cnt_q + BIT_ONE;
          if (bit_last) begin
`ifdef PTS_TX_CONTROLLER_GAP_EN
            state_d = S_GAP;
`else
            state_d = S_IDLE;
`endif
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_ONE;
        end
      end

`ifdef PTS_TX_CONTROLLER_GAP_EN
      // clk_cnt wrapped to 0 on the final shift, so counting it to
      // CLKS_PER_BIT-1 again gives exactly one idle bit period.
      S_GAP: begin
        if (clk_last) begin
          clk_cnt_d = '0;
          state_d   = S_IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_ONE;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      pts_data_q <= '0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      pts_data_q <= pts_data_d;
    end
  end

endmodule

// File: tb/tb_pts_tx_controller.sv
// Testbench for pts_tx_controller.
// Two instances run side by side: dut_a (NUM_BITS=8, CLKS_PER_BIT=4) and
// dut_b (NUM_BITS=8, CLKS_PER_BIT=1). Each one drives a behavioural model
// of the downstream shift register (MSB first, ones shifted in). Words are
// sent as directed steps, and the expected serial bits for each word are
// queued when the word is driven. A negedge monitor pops and compares one
// bit on every shift pulse and also checks bit hold time and pulse rules.

module tb_pts_tx_controller;

  localparam int NB = 8;
`ifdef PTS_TX_CONTROLLER_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic mon_en;

  logic          a_valid, a_ready, a_load, a_shift, a_busy, a_done;
  logic [NB-1:0] a_data, a_pts;
  logic          b_valid, b_ready, b_load, b_shift, b_busy, b_done;
  logic [NB-1:0] b_data, b_pts;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pts_tx_controller #(.NUM_BITS(NB), .CLKS_PER_BIT(4)) dut_a (
    .clk(clk), .rst(rst), .tx_valid(a_valid), .tx_data(a_data),
    .tx_ready(a_ready), .pts_data(a_pts), .load_enable(a_load),
    .shift_enable(a_shift), .busy(a_busy), .tx_done(a_done)
  );

  pts_tx_controller #(.NUM_BITS(NB), .CLKS_PER_BIT(1)) dut_b (
    .clk(clk), .rst(rst), .tx_valid(b_valid), .tx_data(b_data),
    .tx_ready(b_ready), .pts_data(b_pts), .load_enable(b_load),
    .shift_enable(b_shift), .busy(b_busy), .tx_done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Downstream shift register models; serial_out is the MSB.
  logic [NB-1:0] sr_a = '1;
  logic [NB-1:0] sr_b = '1;
  always @(posedge clk) begin
    if (a_load)       sr_a <= a_pts;
    else if (a_shift) sr_a <= {sr_a[NB-2:0], 1'b1};
    if (b_load)       sr_b <= b_pts;
    else if (b_shift) sr_b <= {sr_b[NB-2:0], 1'b1};
  end

  // Scoreboards of expected serial bits, MSB first.
  logic bits_a[$];
  logic bits_b[$];

  task automatic push_a(input logic [NB-1:0] w);
    for (int i = NB - 1; i >= 0; i--) bits_a.push_back(w[i]);
  endtask
  task automatic push_b(input logic [NB-1:0] w);
    for (int i = NB - 1; i >= 0; i--) bits_b.push_back(w[i]);
  endtask

  int loads_a = 0, shifts_a = 0, dones_a = 0, hold_a = 0, idx_a = 0;
  int loads_b = 0, shifts_b = 0, dones_b = 0, hold_b = 0, idx_b = 0;
  logic restart_a = 1'b1, restart_b = 1'b1;
  logic rst_seen_a = 1'b1, rst_seen_b = 1'b1;
  logic [NB-1:0] pts_prev_a, pts_prev_b;
  logic eb_a, eb_b;

  always @(negedge clk) begin
    if (!mon_en || rst) begin
      restart_a  = 1'b1;
      rst_seen_a = 1'b1;
    end else begin
      hold_a    = restart_a ? 1 : hold_a + 1;
      restart_a = a_load | a_shift;
      if (a_pts !== pts_prev_a && !rst_seen_a) chk("a_pts_change_only_at_accept", a_load, 1);
      rst_seen_a = 1'b0;
      if (a_load) begin
        loads_a++;
        idx_a = 0;
      end
      if (a_load | a_shift) chk("a_load_shift_exclusive", a_load & a_shift, 0);
      if (a_shift) begin
        shifts_a++;
        idx_a++;
        chk("a_shift_expected", int'(bits_a.size() > 0), 1);
        if (bits_a.size() > 0) begin
          eb_a = bits_a.pop_front();
          chk("a_serial_bit", sr_a[NB-1], eb_a);
          chk("a_bit_hold_cycles", hold_a, 4);
        end
      end
      if (a_done) begin
        dones_a++;
        chk("a_done_with_shift", a_shift, 1);
        chk("a_done_on_last_bit", idx_a, NB);
      end
    end
    pts_prev_a = a_pts;
  end

  always @(negedge clk) begin
    if (!mon_en || rst) begin
      restart_b  = 1'b1;
      rst_seen_b = 1'b1;
    end else begin
      hold_b    = restart_b ? 1 : hold_b + 1;
      restart_b = b_load | b_shift;
      if (b_pts !== pts_prev_b && !rst_seen_b) chk("b_pts_change_only_at_accept", b_load, 1);
      rst_seen_b = 1'b0;
      if (b_load) begin
        loads_b++;
        idx_b = 0;
      end
      if (b_load | b_shift) chk("b_load_shift_exclusive", b_load & b_shift, 0);
      if (b_shift) begin
        shifts_b++;
        idx_b++;
        chk("b_shift_expected", int'(bits_b.size() > 0), 1);
        if (bits_b.size() > 0) begin
          eb_b = bits_b.pop_front();
          chk("b_serial_bit", sr_b[NB-1], eb_b);
          chk("b_bit_hold_cycles", hold_b, 1);
        end
      end
      if (b_done) begin
        dones_b++;
        chk("b_done_with_shift", b_shift, 1);
        chk("b_done_on_last_bit", idx_b, NB);
      end
    end
    pts_prev_b = b_pts;
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a(output int n);
    n = 0;
    while (a_done !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_ready_a();
    int n;
    n = 0;
    while (a_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk("a_ready_within_bound", a_ready, 1);
  endtask

  initial begin
    int n, n2, s0, d0;
    rst = 1'b1; mon_en = 1'b0;
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;

    // Reset state
    tick();
    chk("rst_a_ready", a_ready, 1);
    chk("rst_a_busy", a_busy, 0);
    chk("rst_a_pts", a_pts, 0);
    chk("rst_a_load", a_load, 0);
    chk("rst_a_shift", a_shift, 0);
    chk("rst_a_done", a_done, 0);
    chk("rst_b_ready", b_ready, 1);
    tick();
    rst = 1'b0;
    mon_en = 1'b1;

    // Idle with no traffic: no pulses at all
    tick(50);
    chk("idle_pulse_count", loads_a + shifts_a + loads_b + shifts_b, 0);
    chk("idle_a_ready", a_ready, 1);
    chk("idle_a_busy", a_busy, 0);

    // Single word 0xA5
    a_data = 8'hA5; a_valid = 1'b1; push_a(8'hA5);
    tick();
    a_valid = 1'b0; a_data = '0;
    chk("a5_load_after_accept", a_load, 1);
    chk("a5_pts_captured", a_pts, 8'hA5);
    chk("a5_busy", a_busy, 1);
    chk("a5_ready_low", a_ready, 0);
    s0 = shifts_a;
    tick();
    chk("a5_load_one_cycle", a_load, 0);
    wait_done_a(n);
    chk("a5_latency", n + 2, 33);
    tick();
    chk("a5_shift_count", shifts_a - s0, 8);
    chk("a5_done_one_cycle", a_done, 0);
    chk("a5_ready_after_done", a_ready, GAP_ON ? 0 : 1);

    // Back-to-back with tx_valid held: 0x3C then 0xFF
    wait_ready_a();
    a_data = 8'h3C; a_valid = 1'b1; push_a(8'h3C);
    tick();
    a_data = 8'hFF; push_a(8'hFF);
    wait_done_a(n);
    chk("b2b_first_latency", n + 1, 33);
    chk("b2b_pts_held_first", a_pts, 8'h3C);
    n2 = 0;
    while (a_load !== 1'b1 && n2 < 50) begin
      tick();
      n2++;
    end
    chk("b2b_done_to_accept", n2 - 1, GAP_ON ? 5 : 1);
    chk("b2b_pts_second", a_pts, 8'hFF);
    a_valid = 1'b0;
    wait_done_a(n);
    chk("b2b_second_latency", n + 1, 33);
    chk("b2b_pts_held_second", a_pts, 8'hFF);
    tick();

    // CLKS_PER_BIT=1 instance: 0x81, shift pulses back to back
    b_data = 8'h81; b_valid = 1'b1; push_b(8'h81);
    tick();
    b_valid = 1'b0;
    chk("c1_load", b_load, 1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("c1_shift_run", b_shift, 1);
      chk("c1_done_position", b_done, (i == 8) ? 1 : 0);
    end
    tick();
    chk("c1_shift_stops", b_shift, 0);
    chk("c1_done_clear", b_done, 0);

    // Mid-frame reset after the 3rd shift pulse
    wait_ready_a();
    a_data = 8'h96; a_valid = 1'b1; push_a(8'h96);
    tick();
    a_valid = 1'b0;
    s0 = shifts_a;
    n = 0;
    while (shifts_a < s0 + 3 && n < 100) begin
      tick();
      n++;
    end
    chk("mid_third_shift_seen", shifts_a - s0, 3);
    d0 = dones_a;
    rst = 1'b1;
    bits_a.delete();
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", a_ready, 1);
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_load", a_load, 0);
    chk("mid_rst_shift", a_shift, 0);
    chk("mid_rst_done", a_done, 0);
    chk("mid_rst_pts", a_pts, 0);
    tick(60);
    chk("mid_rst_no_done", dones_a - d0, 0);
    chk("mid_rst_stays_idle", a_ready, 1);

    // Fresh word after reset
    a_data = 8'h55; a_valid = 1'b1; push_a(8'h55);
    tick();
    a_valid = 1'b0;
    wait_done_a(n);
    chk("post_rst_latency", n + 1, 33);
    chk("post_rst_pts", a_pts, 8'h55);
    tick();

    // tx_data toggling during the frame must be ignored
    wait_ready_a();
    a_data = 8'hC3; a_valid = 1'b1; push_a(8'hC3);
    tick();
    a_valid = 1'b0;
    n = 0;
    while (a_done !== 1'b1 && n < 300) begin
      a_data = ~a_data ^ 8'h5A;
      tick();
      n++;
    end
    chk("ignore_latency", n + 1, 33);
    chk("ignore_pts_held", a_pts, 8'hC3);
    tick(2);

    chk("a_scoreboard_drained", bits_a.size(), 0);
    chk("b_scoreboard_drained", bits_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
